// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with config handshake, arm/abort FSM and match counter
// Config is taken only while not running; a start checks the already-latched length.

module seq_detect_ctrl #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(4'b1011);
    localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_count;
    logic               r_match;

    logic               w_cfg_ok;
    logic               w_beat;
    logic               w_start_ok;
    logic [MAX_LEN-1:0] w_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_enough;
    logic               w_hit;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_max;
    logic               w_reach;

    assign w_cfg_ok   = (r_len >= LEN_W'(2)) && (r_len <= LEN_W'(MAX_LEN));
    assign w_beat     = (r_state == S_RUN) && bit_valid && !abort;
    assign w_start_ok = start && !abort && w_cfg_ok && (r_state != S_RUN);
    assign w_shift    = {r_hist[MAX_LEN-2:0], bit_in};
    assign w_fill_inc = {1'b0, r_fill} + (LEN_W + 1)'(1);
    assign w_enough   = w_fill_inc >= {1'b0, r_len};
    assign w_cnt_inc  = r_count + CNT_W'(1);
    assign w_cnt_max  = &r_count;
    assign w_reach    = (r_target != '0) && (w_cnt_inc == r_target);

    // Only the newest r_len history bits take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_hit = w_beat && w_enough && (((w_shift ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)                 w_state_nxt = S_IDLE;
                else if (w_hit && w_reach) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_start_ok) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= DEF_PAT;
            r_len     <= DEF_LEN;
            r_overlap <= 1'b1;
            r_target  <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_count   <= '0;
            r_match   <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (cfg_valid && cfg_ready) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_target  <= cfg_target;
            end
            if (w_start_ok) begin
                r_hist  <= '0;
                r_fill  <= '0;
                r_count <= '0;
            end else if (w_beat) begin
                r_hist <= w_shift;
                // Without overlap a match consumes its bits; the next needs a full fresh window.
                if (w_hit && !r_overlap) begin
                    r_fill <= '0;
                end else if (r_fill != LEN_W'(MAX_LEN)) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
                if (w_hit && ((r_target != '0) || !w_cnt_max)) begin
                    r_count <= w_cnt_inc;
                end
            end
        end
    end

    assign cfg_ready   = (r_state != S_RUN);
    assign match       = r_match;
    assign match_count = r_count;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule
